// File: rtl/link_sprite_draw.sv
// Link sprite drawing stage: walks the 16x16 sprite ROM and emits one VGA pixel write per cycle.
// Optional macro LINK_MIRROR_EN: facing left reuses the right-facing frame with mirrored columns.
module link_sprite_draw #(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COLOUR_W = 9,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = 9'h1FF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                draw_link,
  input  logic [7:0]          link_x,
  input  logic [6:0]          link_y,
  input  logic [1:0]          link_dir,
  output logic [9:0]          rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                draw_link_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [3:0] LAST_COL = 4'(SPRITE_W - 1);
  localparam logic [3:0] LAST_ROW = 4'(SPRITE_H - 1);
  localparam logic [8:0] X_LIM    = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIM    = 8'(SCREEN_H);

  logic [2:0] state;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [1:0] dir;
  logic [3:0] row;
  logic [3:0] col;
  logic       drain_cnt;
  logic       s1_valid;
  logic [8:0] s1_x;
  logic [7:0] s1_y;
  logic [1:0] frame;
  logic [3:0] addr_col;

  always_comb begin
    frame    = dir;
    addr_col = col;
`ifdef LINK_MIRROR_EN
    if (dir == 2'd2) begin
      frame    = 2'd3;
      addr_col = ~col;
    end
`endif
  end

  assign rom_addr       = {frame, row, addr_col};
  assign draw_link_done = (state == S_DONE);

  // Stage 1 lines up with the ROM read latency; the output registers form stage 2.
  // Sums are kept one bit wider than the ports so off-screen pixels never wrap into view.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      base_x     <= '0;
      base_y     <= '0;
      dir        <= '0;
      row        <= '0;
      col        <= '0;
      drain_cnt  <= 1'b0;
      s1_valid   <= 1'b0;
      s1_x       <= '0;
      s1_y       <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      s1_valid   <= 1'b0;
      s1_x       <= {1'b0, base_x} + {5'b0, col};
      s1_y       <= {1'b0, base_y} + {4'b0, row};
      vga_x      <= s1_x[7:0];
      vga_y      <= s1_y[6:0];
      vga_colour <= rom_data;
      vga_plot   <= s1_valid && (rom_data != TRANSPARENT) && (s1_x < X_LIM) && (s1_y < Y_LIM);

      case (state)
        S_IDLE: begin
          if (draw_link) begin
            base_x <= link_x;
            base_y <= link_y;
            dir    <= link_dir;
            row    <= '0;
            col    <= '0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!draw_link) begin
            vga_plot <= 1'b0;
            state    <= S_IDLE;
          end else begin
            s1_valid <= 1'b1;
            col      <= col + 4'd1;
            if (col == LAST_COL) row <= row + 4'd1;
            if (row == LAST_ROW && col == LAST_COL) begin
              drain_cnt <= 1'b0;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!draw_link) begin
            vga_plot <= 1'b0;
            state    <= S_IDLE;
          end else if (drain_cnt) begin
            state <= S_DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_DONE:    state <= S_RELEASE;
        S_RELEASE: if (!draw_link) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_link_sprite_draw.sv
// Directed testbench for link_sprite_draw with a behavioural synchronous sprite ROM.
module tb_link_sprite_draw;

  logic       clock = 1'b0;
  logic       reset;
  logic       draw_link;
  logic [7:0] link_x;
  logic [6:0] link_y;
  logic [1:0] link_dir;
  logic [9:0] rom_addr;
  logic [8:0] rom_data;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [8:0] vga_colour;
  logic       vga_plot;
  logic       draw_link_done;

  int compared   = 0;
  int mismatched = 0;
  int rom_mode   = 0;

  always #5 clock = ~clock;

  link_sprite_draw dut (
    .clock(clock), .reset(reset), .draw_link(draw_link),
    .link_x(link_x), .link_y(link_y), .link_dir(link_dir),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .draw_link_done(draw_link_done)
  );

  // Mode 0: solid 9'h038; mode 1: transparent on even columns; mode 2: colour = low address byte.
  always @(posedge clock) begin
    case (rom_mode)
      1:       rom_data <= rom_addr[0] ? 9'h038 : 9'h1FF;
      2:       rom_data <= {1'b0, rom_addr[7:0]};
      default: rom_data <= 9'h038;
    endcase
  end

  task start_draw(input logic [7:0] lx, input logic [6:0] ly, input logic [1:0] d);
    @(negedge clock);
    link_x = lx; link_y = ly; link_dir = d; draw_link = 1'b1;
    @(posedge clock);
  endtask

  task finish_draw();
    @(negedge clock);
    draw_link = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  task test_reset();
    reset = 1'b1; draw_link = 1'b0; link_x = 8'd0; link_y = 7'd0; link_dir = 2'd0;
    #1 reset = 1'b0;
    #12;
    compared++;
    if ({vga_x, vga_y, vga_colour} !== 24'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_coords: got %h expected 0", {vga_x, vga_y, vga_colour});
    end
    compared++;
    if ({vga_plot, draw_link_done} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 00", {vga_plot, draw_link_done});
    end
    compared++;
    if (rom_addr !== 10'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_addr: got %h expected 0", rom_addr);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task test_basic();
    int k;
    logic exp_plot;
    logic [7:0] ex_x;
    logic [6:0] ex_y;
    logic [9:0] ex_addr;
    rom_mode = 0;
    start_draw(8'd10, 7'd20, 2'd1);
    for (int c = 1; c <= 262; c++) begin
      @(negedge clock);
      if (c == 5) begin link_x = 8'd77; link_y = 7'd5; link_dir = 2'd3; end
      k = c - 3;
      exp_plot = (c >= 3 && c <= 258);
      compared++;
      if (vga_plot !== exp_plot) begin
        mismatched++;
        $display("[TB] FAIL basic_plot c=%0d: got %b expected %b", c, vga_plot, exp_plot);
      end
      compared++;
      if (draw_link_done !== (c == 259)) begin
        mismatched++;
        $display("[TB] FAIL basic_done c=%0d: got %b expected %b", c, draw_link_done, c == 259);
      end
      if (c <= 256) begin
        ex_addr = {2'd1, 8'(c - 1)};
        compared++;
        if (rom_addr !== ex_addr) begin
          mismatched++;
          $display("[TB] FAIL basic_addr c=%0d: got %h expected %h", c, rom_addr, ex_addr);
        end
      end
      if (exp_plot) begin
        ex_x = 8'(10 + k % 16);
        ex_y = 7'(20 + k / 16);
        compared++;
        if ({vga_x, vga_y, vga_colour} !== {ex_x, ex_y, 9'h038}) begin
          mismatched++;
          $display("[TB] FAIL basic_pixel c=%0d: got x=%0d y=%0d col=%h expected x=%0d y=%0d col=038",
                   c, vga_x, vga_y, vga_colour, ex_x, ex_y);
        end
      end
    end
    finish_draw();
  endtask

  task test_transparency();
    int k;
    int plots;
    logic exp_plot;
    rom_mode = 1;
    plots = 0;
    start_draw(8'd10, 7'd20, 2'd1);
    for (int c = 1; c <= 262; c++) begin
      @(negedge clock);
      k = c - 3;
      exp_plot = (c >= 3 && c <= 258) && (k % 2 == 1);
      if (vga_plot === 1'b1) plots++;
      compared++;
      if (vga_plot !== exp_plot) begin
        mismatched++;
        $display("[TB] FAIL transp_plot c=%0d: got %b expected %b", c, vga_plot, exp_plot);
      end
      compared++;
      if (draw_link_done !== (c == 259)) begin
        mismatched++;
        $display("[TB] FAIL transp_done c=%0d: got %b expected %b", c, draw_link_done, c == 259);
      end
    end
    compared++;
    if (plots !== 128) begin
      mismatched++;
      $display("[TB] FAIL transp_count: got %0d expected 128", plots);
    end
    finish_draw();
  endtask

  task test_clipping();
    int px [3] = '{150, 250, 10};
    int py [3] = '{112, 10, 125};
    int pc [3] = '{80, 0, 0};
    int k;
    int plots;
    logic exp_plot;
    rom_mode = 2;
    for (int t = 0; t < 3; t++) begin
      plots = 0;
      start_draw(8'(px[t]), 7'(py[t]), 2'd0);
      for (int c = 1; c <= 260; c++) begin
        @(negedge clock);
        k = c - 3;
        exp_plot = (c >= 3 && c <= 258) && (px[t] + k % 16 < 160) && (py[t] + k / 16 < 120);
        if (vga_plot === 1'b1) plots++;
        compared++;
        if (vga_plot !== exp_plot) begin
          mismatched++;
          $display("[TB] FAIL clip_plot t=%0d c=%0d: got %b expected %b", t, c, vga_plot, exp_plot);
        end
        if (exp_plot) begin
          compared++;
          if ({vga_x, vga_y, vga_colour} !== {8'(px[t] + k % 16), 7'(py[t] + k / 16), 9'(k)}) begin
            mismatched++;
            $display("[TB] FAIL clip_pixel t=%0d c=%0d: got x=%0d y=%0d col=%h expected x=%0d y=%0d col=%h",
                     t, c, vga_x, vga_y, vga_colour, px[t] + k % 16, py[t] + k / 16, k);
          end
        end
      end
      compared++;
      if (plots !== pc[t]) begin
        mismatched++;
        $display("[TB] FAIL clip_count t=%0d: got %0d expected %0d", t, plots, pc[t]);
      end
      finish_draw();
    end
  endtask

  task test_abort();
    int k;
    logic exp_plot;
    rom_mode = 0;
    start_draw(8'd10, 7'd20, 2'd1);
    for (int c = 1; c <= 110; c++) begin
      @(negedge clock);
      exp_plot = (c >= 3 && c <= 100);
      compared++;
      if (vga_plot !== exp_plot || draw_link_done !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL abort_window c=%0d: got plot=%b done=%b expected plot=%b done=0",
                 c, vga_plot, draw_link_done, exp_plot);
      end
      if (c == 100) draw_link = 1'b0;
      if (c == 110) begin link_x = 8'd60; link_y = 7'd30; draw_link = 1'b1; end
    end
    @(posedge clock);
    for (int c = 1; c <= 260; c++) begin
      @(negedge clock);
      k = c - 3;
      exp_plot = (c >= 3 && c <= 258);
      compared++;
      if (vga_plot !== exp_plot || draw_link_done !== (c == 259)) begin
        mismatched++;
        $display("[TB] FAIL retrigger_ctl c=%0d: got plot=%b done=%b expected plot=%b done=%b",
                 c, vga_plot, draw_link_done, exp_plot, c == 259);
      end
      if (exp_plot) begin
        compared++;
        if ({vga_x, vga_y} !== {8'(60 + k % 16), 7'(30 + k / 16)}) begin
          mismatched++;
          $display("[TB] FAIL retrigger_pixel c=%0d: got x=%0d y=%0d expected x=%0d y=%0d",
                   c, vga_x, vga_y, 60 + k % 16, 30 + k / 16);
        end
      end
    end
    finish_draw();
  endtask

  task test_release();
    rom_mode = 0;
    start_draw(8'd10, 7'd20, 2'd1);
    for (int c = 1; c <= 264; c++) begin
      @(negedge clock);
      compared++;
      if (draw_link_done !== (c == 259)) begin
        mismatched++;
        $display("[TB] FAIL release_done c=%0d: got %b expected %b", c, draw_link_done, c == 259);
      end
      if (c >= 259) begin
        compared++;
        if (vga_plot !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL release_noplot c=%0d: got %b expected 0", c, vga_plot);
        end
      end
    end
    draw_link = 1'b0;
    @(negedge clock);
    start_draw(8'd40, 7'd50, 2'd1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      compared++;
      if (vga_plot !== (c == 3)) begin
        mismatched++;
        $display("[TB] FAIL release_restart_plot c=%0d: got %b expected %b", c, vga_plot, c == 3);
      end
    end
    compared++;
    if ({vga_x, vga_y} !== {8'd40, 7'd50}) begin
      mismatched++;
      $display("[TB] FAIL release_restart_pixel: got x=%0d y=%0d expected x=40 y=50", vga_x, vga_y);
    end
    finish_draw();
  endtask

  task test_reset_mid();
    rom_mode = 0;
    start_draw(8'd10, 7'd20, 2'd1);
    for (int c = 1; c <= 49; c++) @(negedge clock);
    compared++;
    if (vga_plot !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL resetmid_pre: got plot=%b expected 1", vga_plot);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    compared++;
    if ({vga_x, vga_y, vga_colour, vga_plot, draw_link_done} !== 26'd0) begin
      mismatched++;
      $display("[TB] FAIL resetmid_outputs: got %h expected 0",
               {vga_x, vga_y, vga_colour, vga_plot, draw_link_done});
    end
    compared++;
    if (rom_addr !== 10'd0) begin
      mismatched++;
      $display("[TB] FAIL resetmid_addr: got %h expected 0", rom_addr);
    end
    draw_link = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      compared++;
      if (vga_plot !== 1'b0 || draw_link_done !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL resetmid_quiet c=%0d: got plot=%b done=%b expected 0 0",
                 c, vga_plot, draw_link_done);
      end
    end
  endtask

  task test_direction();
    int k;
    logic [9:0] ex_addr;
    rom_mode = 0;
    start_draw(8'd0, 7'd0, 2'd2);
    for (int c = 1; c <= 260; c++) begin
      @(negedge clock);
      if (c <= 256) begin
        k = c - 1;
`ifdef LINK_MIRROR_EN
        ex_addr = {2'd3, 4'(k / 16), 4'(15 - k % 16)};
`else
        ex_addr = {2'd2, 8'(k)};
`endif
        compared++;
        if (rom_addr !== ex_addr) begin
          mismatched++;
          $display("[TB] FAIL dir_addr c=%0d: got %h expected %h", c, rom_addr, ex_addr);
        end
      end
      if (c >= 3 && c <= 18) begin
        compared++;
        if (vga_x !== 8'(c - 3)) begin
          mismatched++;
          $display("[TB] FAIL dir_x c=%0d: got %0d expected %0d", c, vga_x, c - 3);
        end
      end
      compared++;
      if (draw_link_done !== (c == 259)) begin
        mismatched++;
        $display("[TB] FAIL dir_done c=%0d: got %b expected %b", c, draw_link_done, c == 259);
      end
    end
    finish_draw();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_transparency();
    test_clipping();
    test_abort();
    test_release();
    test_reset_mid();
    test_direction();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/link_sprite_draw.md
Name: link_sprite_draw

Overview:
- Drawing stage directly downstream of the game control FSM.
- While control holds draw_link high, this block walks Link's 16x16 sprite out of a synchronous sprite ROM and emits one VGA-adapter pixel write per cycle at Link's current screen position.
- Transparent pixels and off-screen pixels are suppressed.
- Pulses draw_link_done to return control to idle.

Parameters:
- SPRITE_W, 16, sprite width in pixels (power of two; addressing assumes 16).
- SPRITE_H, 16, sprite height in pixels (power of two; addressing assumes 16).
- SCREEN_W, 160, visible columns; x >= SCREEN_W is clipped.
- SCREEN_H, 120, visible rows; y >= SCREEN_H is clipped.
- COLOUR_W, 9, pixel colour width (3 bits per channel).
- TRANSPARENT, 9'h1FF, ROM colour value meaning "do not plot".

Ports:
- clock  in  1  system clock, CLOCK_50.
- reset  in  1  asynchronous, active-low reset.
- draw_link  in  1  level request from control; held high until draw_link_done is seen.
- link_x  in  8  top-left sprite column; sampled at start.
- link_y  in  7  top-left sprite row; sampled at start.
- link_dir  in  2  facing direction (0 up, 1 down, 2 left, 3 right); sampled at start.
- rom_addr  out  10  sprite ROM address {frame[1:0], row[3:0], col[3:0]}.
- rom_data  in  COLOUR_W  ROM output; valid one cycle after rom_addr.
- vga_x  out  8  pixel column.
- vga_y  out  7  pixel row.
- vga_colour  out  COLOUR_W  pixel colour.
- vga_plot  out  1  write-enable to VGA adapter.
- draw_link_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE.
  - vga_x=0, vga_y=0, vga_colour=0, vga_plot=0.
  - draw_link_done=0, rom_addr=0, all counters 0.
- FSM states: IDLE, FETCH, DRAIN, DONE, RELEASE.
- IDLE:
  - On draw_link=1 at edge N: latch link_x, link_y, link_dir; clear row/col counters; go to FETCH.
- FETCH (cycles N+1..N+256):
  - rom_addr = {frame, row, col}; frame = link_dir.
  - col increments every cycle; on col=15 it wraps to 0 and row increments.
  - After {row,col}={15,15}, go to DRAIN.
- Pipeline:
  - A 2-stage valid/coordinate pipeline tracks each issued address.
  - rom_data for address k arrives in cycle N+2+k.
  - Outputs are registered: pixel k appears on vga_* in cycle N+3+k.
  - vga_x = latched_x + col (9-bit sum); vga_y = latched_y + row (8-bit sum); both truncated to port width.
- Plot rule:
  - vga_plot=1 only if the pixel is valid, rom_data != TRANSPARENT, unclipped x sum < SCREEN_W, and unclipped y sum < SCREEN_H.
  - Otherwise vga_plot=0; vga_x, vga_y and vga_colour still update.
- DRAIN: 2 cycles (N+257, N+258) to flush the pipeline. The last pixel appears in N+258.
- DONE: draw_link_done=1 in cycle N+259 only; go to RELEASE.
- RELEASE:
  - Hold until draw_link=0, then go to IDLE.
  - Prevents a retrigger while control is still leaving S_DRAW_LINK.
- Abort: draw_link=0 in FETCH or DRAIN → go to IDLE next edge.
  - In-flight pipeline valids are cleared, so vga_plot=0 from the next cycle.
  - No draw_link_done pulse.
- Inputs are sampled only at start: link_x, link_y and link_dir changing mid-draw has no effect.
- Total latency is 259 cycles from request edge to done, independent of transparency or clipping.
- Reset asserted mid-draw: outputs drop immediately (asynchronously); no done pulse.

Optional Feature:
- Macro: LINK_MIRROR_EN.
- Defined:
  - link_dir=2 (left) reads frame 3 (right) with col inverted (15-col) in rom_addr; vga_x still uses the un-inverted col.
  - ROM frame 2 is unused; all other directions are unchanged.
- Undefined: frame = link_dir directly, with four stored frames.
- Timing is identical in both builds.

Test Plan:
- Basic draw:
  - Stimulus: reset, release; link_x=10, link_y=20, dir=1; ROM returns colour 9'h038 everywhere; draw_link held high.
  - Response: 256 plots covering x 10..25 and y 20..35 in row-major order; first plot at N+3; done pulse at N+259 only; no plot after.
- Transparency:
  - Stimulus: ROM returns 9'h1FF for even col.
  - Response: exactly 128 plots, all at odd col; done still at N+259.
- Clipping:
  - Stimulus: link_x=150, link_y=112.
  - Response: plots only for x 150..159 and y 112..119 (80 plots); no wrapped coordinates plotted.
- Abort and retrigger:
  - Stimulus: drop draw_link at N+100, reassert at N+110.
  - Response: vga_plot=0 from N+101; no done; a fresh draw starts from pixel 0 with newly sampled position.
- Release guard:
  - Stimulus: keep draw_link high for 5 cycles after the done pulse.
  - Response: no restart and no second done; IDLE is re-entered only after draw_link=0.
- Reset mid-draw and mirror:
  - Stimulus: assert reset at N+50; then with LINK_MIRROR_EN, dir=2.
  - Response: reset drives all outputs to 0 immediately. Mirror draw issues rom_addr frame 3 with col sequence 15..0 while vga_x ascends.
